stat_accum: RTL and testbench
=============================

STAT_ACCUM -- requirements
Module: stat_accum

Interface
REQ-001 Parameter D_WIDTH, default 32: sample width in bits; samples are unsigned.
REQ-002 Parameter WIN_LEN, default 16: samples per statistics window; legal range 2..1024.
REQ-003 Derived SUM_W = D_WIDTH + $clog2(WIN_LEN+1); CNT_W = $clog2(WIN_LEN+1).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk_i  in  1  system clock; all logic on rising edge.
REQ-006 rst_ni  in  1  synchronous active-low reset.
REQ-007 fifo_empty_i  in  1  upstream FIFO empty flag.
REQ-008 fifo_data_i  in  D_WIDTH  upstream FIFO read data; valid the cycle after an accepted read.
REQ-009 fifo_rd_en_o  out  1  read request to upstream FIFO.
REQ-010 flush_i  in  1  discard the partial window.
REQ-011 res_ready_i  in  1  downstream accepts the result.
REQ-012 res_valid_o  out  1  result valid.
REQ-013 res_sum_o  out  SUM_W  sum of window samples.
REQ-014 res_min_o / res_max_o  out  D_WIDTH each  window minimum / maximum.
REQ-015 res_cnt_o  out  CNT_W  number of samples in the result; always WIN_LEN when valid.

Function
REQ-016 FSM states SHALL be FILL and HOLD; reset state FILL.
REQ-017 Accepted read = fifo_rd_en_o high at a rising edge; the block SHALL never assert fifo_rd_en_o while fifo_empty_i is high.
REQ-018 In FILL: fifo_rd_en_o = !fifo_empty_i && (issued < WIN_LEN) && !flush_i; issued counts accepted reads in this window.
REQ-019 Read latency SHALL be 1 cycle: a one-bit pending flag set at an accepted read captures fifo_data_i at the next edge.
REQ-020 Capture of the first sample of a window SHALL load min = max = sum = sample; later captures do sum += sample, min/max by unsigned compare.
REQ-021 The sum SHALL never overflow: accumulate at SUM_W bits, zero-extended samples.
REQ-022 When the WIN_LEN-th sample is captured, the FSM SHALL go to HOLD and assert res_valid_o in the next cycle.
REQ-023 In HOLD, fifo_rd_en_o = 0 and all res_* outputs SHALL remain stable until res_valid_o && res_ready_i.
REQ-024 On handshake: clear sum, min, max, issued, captured; return to FILL; reads may resume the following cycle.
REQ-025 Back-to-back reads SHALL sustain one sample per cycle while fifo_empty_i is low.
REQ-026 flush_i in FILL SHALL clear issued, captured, sum, min, max and the pending flag, discarding any in-flight sample; reads resume the cycle after flush_i deasserts.
REQ-027 flush_i in HOLD SHALL be ignored; the result is not discarded.
REQ-028 res_sum_o/res_min_o/res_max_o SHALL read 0 whenever res_valid_o is low.

Reset
REQ-029 While rst_ni is low at an edge: state FILL; fifo_rd_en_o, res_valid_o, res_sum_o, res_min_o, res_max_o, res_cnt_o, counters and pending flag = 0.
REQ-030 Reset asserted mid-window or in HOLD SHALL discard all partial and held results; no sample in flight at reset is captured.
REQ-031 fifo_rd_en_o SHALL be 0 during any cycle in which rst_ni is low.

Verification (D_WIDTH=8, WIN_LEN=4)
REQ-032 Reset: rst_ni low 2 cycles, fifo_empty_i=0 -> fifo_rd_en_o=0, res_valid_o=0, all res_* = 0.
REQ-033 Stream 3,7,1,9, fifo_empty_i=0, res_ready_i=1 -> 4 consecutive reads; res_valid_o rises 2 edges after the 4th accepted read with sum=20, min=1, max=9, cnt=4; valid for 1 cycle.
REQ-034 Same data with fifo_empty_i toggling every cycle -> fifo_rd_en_o never high while empty; identical result.
REQ-035 Backpressure: res_ready_i low 5 cycles after valid -> outputs stable, zero reads; ready high -> handshake, next window's reads start the next cycle.
REQ-036 Width: four samples 0xFF -> sum=0x3FC, min=max=0xFF.
REQ-037 flush_i for 1 cycle after 2 samples (one read in flight) -> in-flight sample dropped; next result covers exactly the 4 following samples.

Source files
------------

// File: rtl/stat_accum_if.sv
// stat_accum_if: upstream FIFO read port and downstream result handshake for stat_accum
interface stat_accum_if #(
    parameter int D_WIDTH = 32,
    parameter int WIN_LEN = 16
);
    localparam int CNT_W = $clog2(WIN_LEN + 1);
    localparam int SUM_W = D_WIDTH + CNT_W;
    logic               fifo_empty_i;
    logic [D_WIDTH-1:0] fifo_data_i;
    logic               fifo_rd_en_o;
    logic               flush_i;
    logic               res_ready_i;
    logic               res_valid_o;
    logic [SUM_W-1:0]   res_sum_o;
    logic [D_WIDTH-1:0] res_min_o;
    logic [D_WIDTH-1:0] res_max_o;
    logic [CNT_W-1:0]   res_cnt_o;
    modport slave (
        input  fifo_empty_i, fifo_data_i, flush_i, res_ready_i,
        output fifo_rd_en_o, res_valid_o, res_sum_o, res_min_o, res_max_o, res_cnt_o
    );
    modport master (
        output fifo_empty_i, fifo_data_i, flush_i, res_ready_i,
        input  fifo_rd_en_o, res_valid_o, res_sum_o, res_min_o, res_max_o, res_cnt_o
    );
endinterface

// File: rtl/stat_accum.sv
// stat_accum: reads WIN_LEN samples from a FIFO and reports their sum, min and max
module stat_accum #(
    parameter int D_WIDTH = 32,
    parameter int WIN_LEN = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    stat_accum_if.slave bus
);
    localparam int CNT_W = $clog2(WIN_LEN + 1);
    localparam int SUM_W = D_WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_LEN);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pend_q;
    logic [SUM_W-1:0]   sum_q;
    logic [D_WIDTH-1:0] min_q;
    logic [D_WIDTH-1:0] max_q;
    logic               rd_en;
    logic               first;
    logic [SUM_W-1:0]   sample_d;
    logic [SUM_W-1:0]   sum_d;
    logic [D_WIDTH-1:0] min_d;
    logic [D_WIDTH-1:0] max_d;

    // Read request is combinational so it drops in the same cycle as empty, flush or reset
    always_comb begin
        rd_en    = rst_ni && state_q == FILL && !bus.fifo_empty_i && issued_q < WIN_CNT && !bus.flush_i;
        first    = cnt_q == '0;
        sample_d = {{CNT_W{1'b0}}, bus.fifo_data_i};
        sum_d    = first ? sample_d : sum_q + sample_d;
        min_d    = (first || bus.fifo_data_i < min_q) ? bus.fifo_data_i : min_q;
        max_d    = (first || bus.fifo_data_i > max_q) ? bus.fifo_data_i : max_q;
    end

    // Window FSM: reset, handshake and flush all start an empty window; a full window moves to HOLD one cycle after its last capture
    always_ff @(posedge clk_i) begin
        if (!rst_ni || (state_q == HOLD && bus.res_ready_i) || (state_q == FILL && bus.flush_i)) begin
            state_q  <= FILL;
            issued_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            sum_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
        end else if (state_q == FILL) begin
            if (rd_en) issued_q <= issued_q + 1'b1;
            pend_q <= rd_en;
            if (pend_q) begin
                sum_q <= sum_d;
                min_q <= min_d;
                max_q <= max_d;
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == WIN_CNT) state_q <= HOLD;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.res_valid_o  = state_q == HOLD;
    assign bus.res_sum_o    = bus.res_valid_o ? sum_q : '0;
    assign bus.res_min_o    = bus.res_valid_o ? min_q : '0;
    assign bus.res_max_o    = bus.res_valid_o ? max_q : '0;
    assign bus.res_cnt_o    = bus.res_valid_o ? cnt_q : '0;
endmodule

// File: tb/tb_stat_accum.sv
// tb_stat_accum: table vectors, corner sequences and random traffic against a window-level model
module tb_stat_accum;
    localparam int DW = 8;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stat_accum_if #(.D_WIDTH(DW), .WIN_LEN(WL)) bus();
    stat_accum #(.D_WIDTH(DW), .WIN_LEN(WL)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    typedef struct packed {
        logic [9:0] sum;
        logic [7:0] mn;
        logic [7:0] mx;
    } res_t;

    typedef struct {
        logic [31:0] smp;
        bit          tog;
        int          delay;
        logic [9:0]  sum;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } vec_t;

    logic [7:0] src[$];
    logic [7:0] win[$];
    res_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         fa, la, vc, hc, hold_reads;
    res_t       hs;
    bit         prev_hold = 1'b0;
    res_t       prev_r;
    res_t       mon_e;
    vec_t       vt[5];
    bit         acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One clock cycle: drive inputs at negedge, note acceptance, update the window model, supply read data after the edge
    task automatic cycle(input bit e, input bit f, input bit r, input bit rs, output bit a);
        logic [7:0] nxt = 8'h00;
        res_t m;
        rst_n = rs;
        bus.flush_i = f;
        bus.res_ready_i = r;
        bus.fifo_empty_i = e || src.size() == 0;
        #1;
        a = bus.fifo_rd_en_o;
        if (!rs) begin
            win.delete();
            exp_q.delete();
        end else if (f) win.delete();
        if (a && src.size() > 0) begin
            nxt = src.pop_front();
            win.push_back(nxt);
            if (win.size() == WL) begin
                m.sum = '0;
                m.mn = 8'hFF;
                m.mx = 8'h00;
                foreach (win[j]) begin
                    m.sum += 10'(win[j]);
                    if (win[j] < m.mn) m.mn = win[j];
                    if (win[j] > m.mx) m.mx = win[j];
                end
                exp_q.push_back(m);
                win.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.fifo_data_i = a ? nxt : 8'($urandom);
    endtask

    // Run until one result handshake, holding ready low for the first 'delay' valid cycles
    task automatic run_until_hs(input bit tog, input int delay);
        int  c = 0;
        int  vcnt = 0;
        bit  done = 1'b0;
        bit  v;
        bit  a;
        fa = -1; la = -1; vc = -1; hc = -1; hold_reads = 0;
        while (!done && c < 200) begin
            v = bus.res_valid_o;
            if (v && vc < 0) vc = c;
            if (v && vcnt >= delay) hs = {bus.res_sum_o, bus.res_min_o, bus.res_max_o};
            cycle(tog && c[0], 1'b0, vcnt >= delay, 1'b1, a);
            if (a) begin
                if (fa < 0) fa = c;
                la = c;
                if (v) hold_reads++;
            end
            if (v && vcnt >= delay) begin
                hc = c;
                done = 1'b1;
            end
            if (v) vcnt++;
            c++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout actual=no_handshake required=handshake");
        end
    endtask

    // Cycle monitor: read gating, idle zeros, hold stability and result scoreboard
    always @(negedge clk) begin
        #2;
        if (!rst_n || bus.fifo_empty_i) chk("rd_en_blocked", 32'(bus.fifo_rd_en_o), 0);
        if (!bus.res_valid_o) chk("idle_zero", 32'({bus.res_sum_o, bus.res_min_o, bus.res_max_o}), 0);
        else begin
            if (prev_hold) chk("hold_stable", 32'({bus.res_sum_o, bus.res_min_o, bus.res_max_o}), 32'(prev_r));
            if (bus.res_ready_i && rst_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.res_sum_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 32'({bus.res_sum_o, bus.res_min_o, bus.res_max_o}), 32'(mon_e));
                    chk("result_cnt", 32'(bus.res_cnt_o), WL);
                end
            end
        end
        prev_hold = rst_n && bus.res_valid_o && !bus.res_ready_i;
        prev_r = {bus.res_sum_o, bus.res_min_o, bus.res_max_o};
    end

    initial begin
        bus.fifo_empty_i = 1'b1;
        bus.fifo_data_i = 8'h00;
        bus.flush_i = 1'b0;
        bus.res_ready_i = 1'b0;
        vt[0] = '{32'h03070109, 1'b0, 0, 10'd20,  8'd1,   8'd9};
        vt[1] = '{32'h03070109, 1'b1, 0, 10'd20,  8'd1,   8'd9};
        vt[2] = '{32'hFFFFFFFF, 1'b0, 0, 10'h3FC, 8'hFF,  8'hFF};
        vt[3] = '{32'h8001FE7F, 1'b0, 5, 10'h1FE, 8'h01,  8'hFE};
        vt[4] = '{32'h00000000, 1'b1, 2, 10'd0,   8'd0,   8'd0};
        @(negedge clk);

        src.push_back(8'hAA);
        src.push_back(8'hAA);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, acc);
        chk("rst_rd_en", 32'(bus.fifo_rd_en_o), 0);
        chk("rst_valid", 32'(bus.res_valid_o), 0);
        chk("rst_sum", 32'(bus.res_sum_o), 0);
        chk("rst_min", 32'(bus.res_min_o), 0);
        chk("rst_max", 32'(bus.res_max_o), 0);
        chk("rst_cnt", 32'(bus.res_cnt_o), 0);
        src.delete();

        for (int i = 0; i < 5; i++) begin
            for (int b = 3; b >= 0; b--) src.push_back(vt[i].smp[b*8 +: 8]);
            run_until_hs(vt[i].tog, vt[i].delay);
            chk("vec_sum", 32'(hs.sum), 32'(vt[i].sum));
            chk("vec_min", 32'(hs.mn), 32'(vt[i].mn));
            chk("vec_max", 32'(hs.mx), 32'(vt[i].mx));
            chk("vec_reads_in_hold", hold_reads, 0);
            chk("vec_valid_one_cycle", 32'(bus.res_valid_o), 0);
            if (i == 0) begin
                chk("vec_consecutive_reads", la - fa, 3);
                chk("vec_valid_latency", vc - la, 3);
            end
        end

        for (int k = 0; k < 8; k++) src.push_back(8'(k * 17 + 3));
        run_until_hs(1'b0, 5);
        chk("bp_reads_in_hold", hold_reads, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
        chk("bp_resume_read", 32'(acc), 1);
        run_until_hs(1'b0, 0);

        src = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd60, 8'd2};
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
            chk("pre_flush_read", 32'(acc), 1);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, acc);
        chk("flush_read", 32'(acc), 0);
        run_until_hs(1'b0, 0);
        chk("flush_sum", 32'(hs.sum), 107);
        chk("flush_min", 32'(hs.mn), 2);
        chk("flush_max", 32'(hs.mx), 60);

        src = '{8'd1, 8'd2, 8'd250, 8'd3, 8'd4, 8'd5};
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk("midrst_read", 32'(acc), 0);
        run_until_hs(1'b0, 0);
        chk("midrst_sum", 32'(hs.sum), 262);
        chk("midrst_min", 32'(hs.mn), 3);
        chk("midrst_max", 32'(hs.mx), 250);

        for (int n = 0; n < 400; n++) begin
            if (src.size() < 4)
                src.push_back(($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 8'hFF : 8'h00) : 8'($urandom));
            cycle($urandom % 4 == 0, ($urandom % 20 == 0) && exp_q.size() == 0, $urandom % 3 != 0, 1'b1, acc);
        end
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) cycle(1'b1, 1'b0, 1'b1, 1'b1, acc);
        chk("drain_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
